// File: rtl/frame_pkg.sv
// Shared types for the store-and-forward frame checker.
package frame_pkg;
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {CSUM = 2'd0, SHORT = 2'd1, LONG = 2'd2, OVF = 2'd3} drop_reason_e;
    typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, DISCARD = 2'd2} state_e;
endpackage

// File: rtl/sff_ram.sv
// Frame byte buffer: one synchronous write port, one asynchronous read port.
module sff_ram
    import frame_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [BYTE_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [BYTE_W-1:0] rdata
);
    logic [BYTE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/frame_store_fwd.sv
// Store-and-forward frame buffer: checks length and XOR checksum, releases only
// good frames on a valid/ready egress and rolls bad ones back.
module frame_store_fwd
    import frame_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int MIN_LEN = 2,
    parameter int MAX_LEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_en,
    output logic [BYTE_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              frm_ok,
    output logic              frm_drop,
    output logic [1:0]        drop_reason,
    output logic [15:0]       frm_cnt,
    output logic [15:0]       drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int LW = $clog2(MAX_LEN + 2) + 1;

    state_e            state, state_nx;
    logic [PW-1:0]     wr_ptr, commit_ptr, rd_ptr, wr_prev;
    logic [LW-1:0]     len;
    logic [BYTE_W-1:0] csum, ram_data;
    logic              ovf, lng, full, len_over, bad;
    logic              wr_en, set_ovf, set_long, eof;
    logic [DEPTH-1:0]  last;
    drop_reason_e      reason;

    assign full     = (wr_ptr - rd_ptr) == PW'(DEPTH);
    assign len_over = len >= LW'(MAX_LEN);
    assign wr_prev  = wr_ptr - PW'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (rx_en) state_nx = full ? DISCARD : RECV;
            RECV:    if (!rx_en) state_nx = IDLE;
                     else if (full || len_over) state_nx = DISCARD;
            DISCARD: if (!rx_en) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Full is checked ahead of length so an overflowing byte reports OVF.
    always_comb begin
        wr_en    = 1'b0;
        set_ovf  = 1'b0;
        set_long = 1'b0;
        eof      = 1'b0;
        case (state)
            IDLE: begin
                wr_en   = rx_en && !full;
                set_ovf = rx_en && full;
            end
            RECV: begin
                wr_en    = rx_en && !full && !len_over;
                set_ovf  = rx_en && full;
                set_long = rx_en && !full && len_over;
                eof      = !rx_en;
            end
            DISCARD: eof = !rx_en;
            default: ;
        endcase
    end

    always_comb begin
        bad    = 1'b1;
        reason = CSUM;
        if (ovf)                      reason = OVF;
        else if (lng)                 reason = LONG;
        else if (len < LW'(MIN_LEN))  reason = SHORT;
        else if (csum != '0)          reason = CSUM;
        else                          bad    = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            commit_ptr  <= '0;
            rd_ptr      <= '0;
            len         <= '0;
            csum        <= '0;
            ovf         <= 1'b0;
            lng         <= 1'b0;
            last        <= '0;
            frm_ok      <= 1'b0;
            frm_drop    <= 1'b0;
            drop_reason <= '0;
            frm_cnt     <= '0;
            drop_cnt    <= '0;
        end else begin
            frm_ok   <= 1'b0;
            frm_drop <= 1'b0;
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (rx_en) begin
                if (state == IDLE) begin
                    len  <= LW'(1);
                    csum <= rx_data;
                    ovf  <= set_ovf;
                    lng  <= 1'b0;
                end else begin
                    if (len != '1) len <= len + LW'(1);
                    if (wr_en)    csum <= csum ^ rx_data;
                    if (set_ovf)  ovf  <= 1'b1;
                    if (set_long) lng  <= 1'b1;
                end
            end
            if (eof) begin
                if (bad) begin
                    wr_ptr      <= commit_ptr;
                    frm_drop    <= 1'b1;
                    drop_reason <= reason;
                    if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
                end else begin
                    commit_ptr          <= wr_ptr;
                    last[wr_prev[AW-1:0]] <= 1'b1;
                    frm_ok              <= 1'b1;
                    if (frm_cnt != 16'hFFFF) frm_cnt <= frm_cnt + 16'd1;
                end
            end
            // The slot being read is always committed, never the one tagged above.
            if (m_valid && m_ready) begin
                rd_ptr               <= rd_ptr + PW'(1);
                last[rd_ptr[AW-1:0]] <= 1'b0;
            end
        end
    end

    sff_ram #(.DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (rx_data),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (ram_data)
    );

    assign m_valid = rd_ptr != commit_ptr;
    assign m_data  = m_valid ? ram_data : '0;
    assign m_last  = m_valid && last[rd_ptr[AW-1:0]];
endmodule

// File: tb/tb_frame_store_fwd.sv
// Randomized bench for frame_store_fwd with a queue-based frame/egress model.
module tb_frame_store_fwd;
    localparam int DEPTH = 64, MIN_LEN = 2, MAX_LEN = 32;
    localparam logic [1:0] R_CSUM = 2'd0, R_SHORT = 2'd1, R_LONG = 2'd2, R_OVF = 2'd3;

    logic        clk = 1'b0, rst_n = 1'b0, rx_en = 1'b0, m_ready = 1'b0;
    logic [7:0]  rx_data = '0, m_data;
    logic        m_valid, m_last, frm_ok, frm_drop;
    logic [1:0]  drop_reason;
    logic [15:0] frm_cnt, drop_cnt;

    int n_tests = 0, n_fail = 0;
    int rdy_mode = 0;
    int popped = 0;
    int exp_frm = 0, exp_drop = 0;
    logic [8:0] expq[$];

    frame_store_fwd #(.DEPTH(DEPTH), .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_en(rx_en),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .frm_ok(frm_ok), .frm_drop(frm_drop), .drop_reason(drop_reason),
        .frm_cnt(frm_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    // Egress: drive m_ready and score every accepted byte against the model queue.
    initial begin : egress
        logic       r;
        logic [8:0] e, held;
        bit         hold_pend;
        hold_pend = 0;
        forever begin
            @(negedge clk);
            r = (rdy_mode == 1) || (rdy_mode == 2 && $urandom_range(0, 1) == 1);
            m_ready = r;
            if (!rst_n) begin
                hold_pend = 0;
            end else begin
                if (hold_pend) begin
                    n_tests++;
                    if (!(m_valid && {m_last, m_data} === held)) begin
                        n_fail++;
                        $display("FAIL egress_stable got=%b/%b/%h required=1/%b/%h",
                                 m_valid, m_last, m_data, held[8], held[7:0]);
                    end
                end
                hold_pend = 0;
                if (m_valid && r) begin
                    n_tests++;
                    if (expq.size() == 0) begin
                        n_fail++;
                        $display("FAIL egress_extra got=%b/%h required=no byte", m_last, m_data);
                    end else begin
                        e = expq.pop_front();
                        popped++;
                        if ({m_last, m_data} !== e) begin
                            n_fail++;
                            $display("FAIL egress_byte got=%b/%h required=%b/%h",
                                     m_last, m_data, e[8], e[7:0]);
                        end
                    end
                end else if (m_valid) begin
                    held      = {m_last, m_data};
                    hold_pend = 1;
                end
            end
        end
    end

    function automatic void rand_good(input int n, output logic [7:0] b[$]);
        logic [7:0] x;
        x = '0;
        b = {};
        for (int i = 0; i < n - 1; i++) begin
            b.push_back(8'($urandom));
            x ^= b[i];
        end
        b.push_back(x);
    endfunction

    task automatic send_frame(input logic [7:0] b[$], input string name);
        int         n, pend, lim;
        logic [7:0] x;
        bit         bad;
        logic [1:0] er;
        n    = b.size();
        pend = expq.size();
        x    = '0;
        foreach (b[i]) x ^= b[i];
        lim = (n < MAX_LEN + 1) ? n : MAX_LEN + 1;
        bad = 1; er = R_CSUM;
        if (rdy_mode == 0 && pend + lim - 1 >= DEPTH) er = R_OVF;
        else if (n > MAX_LEN)                         er = R_LONG;
        else if (n < MIN_LEN)                         er = R_SHORT;
        else if (x != 0)                              er = R_CSUM;
        else                                          bad = 0;
        foreach (b[i]) begin
            rx_en = 1'b1; rx_data = b[i];
            @(negedge clk);
        end
        rx_en = 1'b0; rx_data = '0;
        if (!bad) for (int i = 0; i < n; i++) expq.push_back({i == n - 1, b[i]});
        @(negedge clk);
        n_tests++;
        if ({frm_ok, frm_drop} !== {!bad, bad}) begin
            n_fail++;
            $display("FAIL %s_status got ok/drop=%b%b required=%b%b", name, frm_ok, frm_drop, !bad, bad);
        end
        if (bad) begin
            n_tests++;
            if (!(drop_reason === er || (er == R_OVF && n > MAX_LEN && drop_reason === R_LONG))) begin
                n_fail++;
                $display("FAIL %s_reason got=%0d required=%0d", name, drop_reason, er);
            end
            if (exp_drop < 65535) exp_drop++;
        end else begin
            if (exp_frm < 65535) exp_frm++;
            if (pend == 0) begin
                n_tests++;
                if (!(m_valid && m_data === b[0])) begin
                    n_fail++;
                    $display("FAIL %s_latency got=%b/%h required=1/%h", name, m_valid, m_data, b[0]);
                end
            end
        end
        n_tests++;
        if (frm_cnt !== 16'(exp_frm) || drop_cnt !== 16'(exp_drop)) begin
            n_fail++;
            $display("FAIL %s_counters got=%0d/%0d required=%0d/%0d", name, frm_cnt, drop_cnt, exp_frm, exp_drop);
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 1000 && expq.size() > 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        n_tests++;
        if (expq.size() != 0 || m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_drain got pending=%0d valid=%b required=0/0", name, expq.size(), m_valid);
        end
    endtask

    task automatic check_zero(input string name);
        n_tests++;
        if ({m_data, m_valid, m_last, frm_ok, frm_drop, drop_reason, frm_cnt, drop_cnt} !== '0) begin
            n_fail++;
            $display("FAIL %s got d=%h v=%b l=%b ok=%b dr=%b r=%0d fc=%0d dc=%0d required=all 0",
                     name, m_data, m_valid, m_last, frm_ok, frm_drop, drop_reason, frm_cnt, drop_cnt);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_good();
        rdy_mode = 1;
        send_frame('{8'h11, 8'h22, 8'h33}, "good");
        drain("good");
    endtask

    task automatic test_csum();
        send_frame('{8'h11, 8'h22, 8'h34}, "csum");
        repeat (4) @(negedge clk);
        n_tests++;
        if (m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL csum_hidden got valid=%b required=0", m_valid);
        end
    endtask

    task automatic test_short_long();
        logic [7:0] b[$];
        send_frame('{8'h00}, "short");
        rand_good(MAX_LEN + 1, b);
        send_frame(b, "long");
        rand_good(5, b);
        send_frame(b, "after_drop");
        drain("after_drop");
    endtask

    task automatic test_ovf();
        logic [7:0] b[$];
        rdy_mode = 0;
        repeat (2) @(negedge clk);
        rand_good(MAX_LEN, b);
        send_frame(b, "ovf_first");
        rand_good(40, b);
        send_frame(b, "ovf_second");
        popped   = 0;
        rdy_mode = 1;
        drain("ovf");
        n_tests++;
        if (popped != MAX_LEN) begin
            n_fail++;
            $display("FAIL ovf_count got=%0d required=%0d", popped, MAX_LEN);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b[$];
        rdy_mode = 2;
        for (int k = 0; k < 4; k++) begin
            rand_good($urandom_range(MIN_LEN, 16), b);
            send_frame(b, "b2b");
        end
        drain("b2b");
    endtask

    task automatic test_reset_mid();
        logic [7:0] b[$];
        rdy_mode = 0;
        rand_good(12, b);
        send_frame(b, "mid_pre");
        rdy_mode = 2;
        for (int i = 0; i < 5; i++) begin
            rx_en = 1'b1; rx_data = 8'($urandom);
            @(negedge clk);
        end
        rst_n = 1'b0; rx_en = 1'b0; rx_data = '0;
        expq.delete();
        exp_frm = 0; exp_drop = 0;
        @(negedge clk);
        check_zero("reset_mid");
        rst_n = 1'b1;
        @(negedge clk);
        rdy_mode = 1;
        rand_good(7, b);
        send_frame(b, "post_reset");
        drain("post_reset");
    endtask

    initial begin
        test_reset();
        test_good();
        test_csum();
        test_short_long();
        test_ovf();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
